// File: rtl/dm_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus access payload.
interface dm_arbiter_if #(parameter int ADDR_W = 32);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        ctrl;
    logic              we;
    logic [ADDR_W-1:0] wdata;
    logic [ADDR_W-1:0] pc;
    logic              done;
    logic              err;

    modport master (output req, addr, ctrl, we, wdata, pc, input done, err);
    modport slave  (input req, addr, ctrl, we, wdata, pc, output done, err);
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory (IDLE -> ACCESS -> RESP).
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dm_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dm_arbiter_if.slave       p0,
    dm_arbiter_if.slave       p1,
    output logic [ADDR_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] dm_a_o,
    output logic [ADDR_W-1:0] dm_wd_o,
    output logic [ADDR_W-1:0] dm_pc_o,
    output logic [2:0]        dm_ctrl_o,
    output logic              dm_we_o,
    input  logic [ADDR_W-1:0] dm_rd_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rdata_q, rdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic              gnt;
    logic [ADDR_W-1:0] sel_addr, sel_wdata, sel_pc;
    logic [2:0]        sel_ctrl;
    logic              sel_we, sel_bad, resp;

`ifdef DM_ARB_RR_EN
    logic rr_q, rr_d;
    // rr_q names the port favoured on the next simultaneous request
    assign gnt = (p0.req && p1.req) ? rr_q : !p0.req;
`else
    assign gnt = !p0.req;
`endif

    function automatic logic illegal(input logic [2:0] ctrl, input logic [1:0] a, input logic we);
        logic bad;
        bad = 1'b0;
        if (ctrl > 3'd4)                                  bad = 1'b1;
        if (ctrl == 3'b000 && a != 2'b00)                 bad = 1'b1;
        if ((ctrl == 3'b001 || ctrl == 3'b011) && a[0])   bad = 1'b1;
        if (we && (ctrl == 3'b011 || ctrl == 3'b100))     bad = 1'b1;
        return bad;
    endfunction

    assign sel_addr  = gnt ? p1.addr  : p0.addr;
    assign sel_ctrl  = gnt ? p1.ctrl  : p0.ctrl;
    assign sel_we    = gnt ? p1.we    : p0.we;
    assign sel_wdata = gnt ? p1.wdata : p0.wdata;
    assign sel_pc    = gnt ? p1.pc    : p0.pc;
    assign sel_bad   = illegal(sel_ctrl, sel_addr[1:0], sel_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef DM_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            err_q   <= err_d;
`ifdef DM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        ctrl_d  = ctrl_q;
        we_d    = we_q;
        err_d   = err_q;
`ifdef DM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (p0.req || p1.req) begin
                    port_d  = gnt;
                    addr_d  = sel_addr;
                    ctrl_d  = sel_ctrl;
                    we_d    = sel_we;
                    wdata_d = sel_wdata;
                    pc_d    = sel_pc;
                    err_d   = sel_bad;
`ifdef DM_ARB_RR_EN
                    rr_d    = !gnt;
`endif
                    if (sel_bad) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                rdata_d = dm_rd_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs hold the last latched request; only the write enable is state-gated
    assign dm_a_o    = addr_q;
    assign dm_wd_o   = wdata_q;
    assign dm_pc_o   = pc_q;
    assign dm_ctrl_o = ctrl_q;
    assign dm_we_o   = (state_q == ACCESS) && we_q && !reset;
    assign rdata_o   = rdata_q;

    assign resp    = (state_q == RESP);
    assign p0.done = resp && !err_q && !port_q;
    assign p1.done = resp && !err_q &&  port_q;
    assign p0.err  = resp &&  err_q && !port_q;
    assign p1.err  = resp &&  err_q &&  port_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory and a response scoreboard.
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rdata, dm_a, dm_wd, dm_pc, dm_rd;
    logic [2:0]  dm_ctrl;
    logic        dm_we;

    dm_arbiter_if p0_if ();
    dm_arbiter_if p1_if ();

    dm_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .p0       (p0_if),
        .p1       (p1_if),
        .rdata_o  (rdata),
        .dm_a_o   (dm_a),
        .dm_wd_o  (dm_wd),
        .dm_pc_o  (dm_pc),
        .dm_ctrl_o(dm_ctrl),
        .dm_we_o  (dm_we),
        .dm_rd_i  (dm_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [31:0] mw;
    logic [15:0] mh;
    logic [7:0]  mb;
    int          we_cnt = 0;

    always_comb begin
        mw = mem[dm_a[7:2]];
        mh = dm_a[1] ? mw[31:16] : mw[15:0];
        mb = mw[8*dm_a[1:0] +: 8];
        case (dm_ctrl)
            3'b001:  dm_rd = {{16{mh[15]}}, mh};
            3'b011:  dm_rd = {16'd0, mh};
            3'b010:  dm_rd = {{24{mb[7]}}, mb};
            3'b100:  dm_rd = {24'd0, mb};
            default: dm_rd = mw;
        endcase
    end

    always @(posedge clk) begin
        if (dm_we) begin
            we_cnt <= we_cnt + 1;
            case (dm_ctrl)
                3'b001: begin
                    if (dm_a[1]) mem[dm_a[7:2]][31:16] <= dm_wd[15:0];
                    else         mem[dm_a[7:2]][15:0]  <= dm_wd[15:0];
                end
                3'b010:  mem[dm_a[7:2]][8*dm_a[1:0] +: 8] <= dm_wd[7:0];
                default: mem[dm_a[7:2]] <= dm_wd;
            endcase
        end
    end

    typedef struct {
        bit          port;
        bit          err;
        bit          chk_rd;
        logic [31:0] rdata;
        logic [31:0] addr;
        bit          we;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic drive(input bit port, input logic [31:0] addr, input logic [2:0] ctrl,
                         input bit we, input logic [31:0] wd);
        if (port) begin
            p1_if.addr = addr; p1_if.ctrl = ctrl; p1_if.we = we;
            p1_if.wdata = wd; p1_if.pc = pc_of(addr); p1_if.req = 1'b1;
        end else begin
            p0_if.addr = addr; p0_if.ctrl = ctrl; p0_if.we = we;
            p0_if.wdata = wd; p0_if.pc = pc_of(addr); p0_if.req = 1'b1;
        end
    endtask

    task automatic release_all();
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
    endtask

    // Waits (bounded) for the next done/err pulse and scores it against the queue head
    task automatic wait_resp(input string tag, input bit chk_access, output int lat);
        exp_t e;
        bit   to;
        int   pulses;
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            lat++;
            if (p0_if.done || p1_if.done || p0_if.err || p1_if.err) begin
                to = 1'b0;
                break;
            end
            if (chk_access && lat == 1 && sb.size() > 0) begin
                chk({tag, " dm_A"},  dm_a,  sb[0].addr);
                chk({tag, " dm_WE"}, {31'd0, dm_we}, {31'd0, sb[0].we});
                chk({tag, " dm_PC"}, dm_pc, sb[0].pc);
            end
        end
        chk({tag, " timeout"}, {31'd0, to}, 32'd0);
        if (to || sb.size() == 0) return;
        e = sb.pop_front();
        pulses = int'(p0_if.done) + int'(p1_if.done) + int'(p0_if.err) + int'(p1_if.err);
        chk({tag, " pulses"}, pulses, 32'd1);
        chk({tag, " port"}, {31'd0, p1_if.done | p1_if.err}, {31'd0, e.port});
        chk({tag, " err"},  {31'd0, p0_if.err | p1_if.err},  {31'd0, e.err});
        if (e.chk_rd) chk({tag, " rdata"}, rdata, e.rdata);
    endtask

    task automatic xact(input string tag, input bit port, input logic [31:0] addr,
                        input logic [2:0] ctrl, input bit we, input logic [31:0] wd,
                        input bit e_err, input bit chk_rd, input logic [31:0] e_rd);
        int lat, wc;
        exp_t e;
        wc = we_cnt;
        e = '{port, e_err, chk_rd || e_err, e_err ? 32'h0 : e_rd, addr, we, pc_of(addr)};
        sb.push_back(e);
        drive(port, addr, ctrl, we, wd);
        wait_resp(tag, !e_err, lat);
        release_all();
        chk({tag, " latency"}, lat, e_err ? 32'd1 : 32'd2);
        chk({tag, " we pulses"}, we_cnt - wc, (we && !e_err) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, wc;
        exp_t e;
        bit   order [4];
        reset = 1'b1;
        release_all();
        p0_if.addr = '0; p0_if.ctrl = '0; p0_if.we = 1'b0; p0_if.wdata = '0; p0_if.pc = '0;
        p1_if.addr = '0; p1_if.ctrl = '0; p1_if.we = 1'b0; p1_if.wdata = '0; p1_if.pc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst dm_WE",  {31'd0, dm_we}, 32'd0);
        chk("rst dm_A",   dm_a, 32'd0);
        chk("rst dm_WD",  dm_wd, 32'd0);
        chk("rst dm_ctrl", {29'd0, dm_ctrl}, 32'd0);
        chk("rst rdata",  rdata, 32'd0);
        chk("rst pulses", {28'd0, p0_if.done, p1_if.done, p0_if.err, p1_if.err}, 32'd0);

        xact("wr 0x10",      1'b0, 32'h10, 3'b000, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        xact("rd 0x10",      1'b0, 32'h10, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        xact("wr 0x20",      1'b0, 32'h20, 3'b000, 1'b1, 32'h000080FF, 1'b0, 1'b0, 32'h0);
        xact("lb 0x21",      1'b1, 32'h21, 3'b010, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
        xact("lbu 0x21",     1'b1, 32'h21, 3'b100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00000080);
        xact("lh 0x20",      1'b1, 32'h20, 3'b001, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF80FF);
        xact("lhu 0x20",     1'b0, 32'h20, 3'b011, 1'b0, 32'h0, 1'b0, 1'b1, 32'h000080FF);
        xact("rd then err",  1'b0, 32'h10, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        xact("mis word 0x22", 1'b0, 32'h22, 3'b000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        xact("lhu store",    1'b1, 32'h20, 3'b011, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h0);
        xact("ctrl 101",     1'b0, 32'h10, 3'b101, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        xact("mis half 0x21", 1'b1, 32'h21, 3'b001, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        xact("sb 0x23",      1'b1, 32'h23, 3'b010, 1'b1, 32'h000000AB, 1'b0, 1'b0, 32'h0);
        xact("rd 0x20",      1'b0, 32'h20, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAB0080FF);

        // Reset lands in the ACCESS cycle of a store: nothing may reach memory
        xact("wr 0x30",      1'b0, 32'h30, 3'b000, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        wc = we_cnt;
        drive(1'b0, 32'h30, 3'b000, 1'b1, 32'h12345678);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort dm_WE", {31'd0, dm_we}, 32'd0);
        @(negedge clk);
        release_all();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort pulses", {28'd0, p0_if.done, p1_if.done, p0_if.err, p1_if.err}, 32'd0);
        chk("abort dm_A", dm_a, 32'd0);
        chk("abort dm_WD", dm_wd, 32'd0);
        chk("abort rdata", rdata, 32'd0);
        chk("abort we pulses", we_cnt - wc, 32'd0);
        xact("rd 0x30 old",  1'b0, 32'h30, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

        // Both ports hold their requests for four back-to-back accesses
        pulse_reset();
`ifdef DM_ARB_RR_EN
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 4; k++) begin
            e = '{order[k], 1'b0, 1'b1, order[k] ? 32'hAB0080FF : 32'hDEADBEEF,
                  order[k] ? 32'h20 : 32'h10, 1'b0, 32'h0};
            sb.push_back(e);
        end
        drive(1'b0, 32'h10, 3'b000, 1'b0, 32'h0);
        drive(1'b1, 32'h20, 3'b000, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_resp("contend", 1'b0, lat);
            chk("contend latency", lat, (k == 0) ? 32'd2 : 32'd3);
        end
        release_all();
        @(negedge clk);
        chk("sb drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
